decode_regfile_scoreboard: RTL

- Decode-stage receiver of the writeback interface.
- Holds the scalar register file and the vector register file, and commits scalar/vector writebacks.
- Supplies combinational source operands with same-cycle write-through bypass.
- Keeps a per-register pending-write scoreboard that produces the dependency stall fed back down the pipeline.

---
 rtl/decode_regfile_scoreboard.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/decode_regfile_scoreboard.sv
// Decode-stage register files with a pending-write scoreboard.
// Holds the scalar and vector register files, commits writebacks, serves
// combinational operands with same-cycle bypass, and raises the dependency
// stall whenever a used source or the issued destination has a write in flight.
module decode_regfile_scoreboard #(
    parameter int unsigned REG_WIDTH  = 16,
    parameter int unsigned VREG_WIDTH = 64,
    parameter int unsigned NUM_SREGS  = 16,
    parameter int unsigned NUM_VREGS  = 64
) (
    input  logic                         I_CLOCK,
    input  logic                         I_RESET,
    input  logic                         I_LOCK,
    input  logic                         I_WriteBackEnable,
    input  logic                         I_VWriteBackEnable,
    input  logic [$clog2(NUM_VREGS)-1:0] I_WriteBackRegIdx,
    input  logic [REG_WIDTH-1:0]         I_WriteBackData,
    input  logic [VREG_WIDTH-1:0]        I_VWriteBackData,
    input  logic                         I_IssueValid,
    input  logic                         I_IssueIsVec,
    input  logic [$clog2(NUM_VREGS)-1:0] I_IssueDestIdx,
    input  logic [$clog2(NUM_SREGS)-1:0] I_Src1Idx,
    input  logic [$clog2(NUM_SREGS)-1:0] I_Src2Idx,
    input  logic [$clog2(NUM_VREGS)-1:0] I_VSrc1Idx,
    input  logic [$clog2(NUM_VREGS)-1:0] I_VSrc2Idx,
    input  logic                         I_Src1Used,
    input  logic                         I_Src2Used,
    input  logic                         I_VSrc1Used,
    input  logic                         I_VSrc2Used,
    output logic [REG_WIDTH-1:0]         O_Src1Data,
    output logic [REG_WIDTH-1:0]         O_Src2Data,
    output logic [VREG_WIDTH-1:0]        O_VSrc1Data,
    output logic [VREG_WIDTH-1:0]        O_VSrc2Data,
    output logic                         O_DepStall,
    output logic [6:0]                   O_BusyCount
);

    localparam int unsigned SIdxWidth = $clog2(NUM_SREGS);
    localparam int unsigned VIdxWidth = $clog2(NUM_VREGS);
    localparam int unsigned CntWidth  = 7;

    // Architectural state
    logic [REG_WIDTH-1:0]  sRegs [NUM_SREGS];
    logic [VREG_WIDTH-1:0] vRegs [NUM_VREGS];
    logic [NUM_SREGS-1:0]  sBusy;
    logic [NUM_VREGS-1:0]  vBusy;
    logic [CntWidth-1:0]   busyCount;

    // Decoded writeback / issue controls
    logic                 sWrite;
    logic                 vWrite;
    logic [SIdxWidth-1:0] sWbIdx;
    logic [VIdxWidth-1:0] vWbIdx;
    logic [SIdxWidth-1:0] sDestIdx;
    logic [VIdxWidth-1:0] vDestIdx;
    logic [NUM_SREGS-1:0] sWbMask;
    logic [NUM_VREGS-1:0] vWbMask;
    logic [NUM_SREGS-1:0] sBusyAfterWb;
    logic [NUM_VREGS-1:0] vBusyAfterWb;
    logic                 depStall;
    logic                 issueAccept;
    logic [NUM_SREGS-1:0] sBusyNext;
    logic [NUM_VREGS-1:0] vBusyNext;
    logic                 sClear;
    logic                 vClear;
    logic [CntWidth-1:0]  busyCountNext;

    // Qualify writebacks with the pipeline-valid lock and build clear masks
    always_comb begin
        sWbIdx   = I_WriteBackRegIdx[SIdxWidth-1:0];
        vWbIdx   = I_WriteBackRegIdx;
        sDestIdx = I_IssueDestIdx[SIdxWidth-1:0];
        vDestIdx = I_IssueDestIdx;
        sWrite   = I_LOCK & I_WriteBackEnable;
        vWrite   = I_LOCK & I_VWriteBackEnable;
        sWbMask  = sWrite ? (NUM_SREGS'(1) << sWbIdx) : '0;
        vWbMask  = vWrite ? (NUM_VREGS'(1) << vWbIdx) : '0;
        // A register being written back this cycle no longer blocks anyone
        sBusyAfterWb = sBusy & ~sWbMask;
        vBusyAfterWb = vBusy & ~vWbMask;
    end

    // Operand read with same-cycle writeback bypass
    always_comb begin
        O_Src1Data  = sRegs[I_Src1Idx];
        O_Src2Data  = sRegs[I_Src2Idx];
        O_VSrc1Data = vRegs[I_VSrc1Idx];
        O_VSrc2Data = vRegs[I_VSrc2Idx];
        if (sWrite && (sWbIdx == I_Src1Idx)) begin
            O_Src1Data = I_WriteBackData;
        end
        if (sWrite && (sWbIdx == I_Src2Idx)) begin
            O_Src2Data = I_WriteBackData;
        end
        if (vWrite && (vWbIdx == I_VSrc1Idx)) begin
            O_VSrc1Data = I_VWriteBackData;
        end
        if (vWrite && (vWbIdx == I_VSrc2Idx)) begin
            O_VSrc2Data = I_VWriteBackData;
        end
    end

    // RAW hazards on used sources plus WAW on the issued destination
    always_comb begin
        logic rawStall;
        logic wawStall;
        rawStall = (I_Src1Used  & sBusyAfterWb[I_Src1Idx])
                 | (I_Src2Used  & sBusyAfterWb[I_Src2Idx])
                 | (I_VSrc1Used & vBusyAfterWb[I_VSrc1Idx])
                 | (I_VSrc2Used & vBusyAfterWb[I_VSrc2Idx]);
        wawStall = I_IssueValid
                 & (I_IssueIsVec ? vBusyAfterWb[vDestIdx] : sBusyAfterWb[sDestIdx]);
        depStall    = I_LOCK & (rawStall | wawStall);
        issueAccept = I_LOCK & I_IssueValid & ~depStall;
        O_DepStall  = depStall;
    end

    // Next busy state: clears first, then the issue set so a younger write wins
    always_comb begin
        sBusyNext = sBusyAfterWb;
        vBusyNext = vBusyAfterWb;
        if (issueAccept) begin
            if (I_IssueIsVec) begin
                vBusyNext[vDestIdx] = 1'b1;
            end else begin
                sBusyNext[sDestIdx] = 1'b1;
            end
        end
    end

    // Busy count tracks set bits incrementally; only real clears decrement
    always_comb begin
        sClear        = sWrite & sBusy[sWbIdx];
        vClear        = vWrite & vBusy[vWbIdx];
        busyCountNext = busyCount
                      + CntWidth'(issueAccept)
                      - CntWidth'(sClear)
                      - CntWidth'(vClear);
    end

    // Scalar register file commit
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            for (int i = 0; i < NUM_SREGS; i++) begin
                sRegs[i] <= '0;
            end
        end else if (sWrite) begin
            sRegs[sWbIdx] <= I_WriteBackData;
        end
    end

    // Vector register file commit
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            for (int i = 0; i < NUM_VREGS; i++) begin
                vRegs[i] <= '0;
            end
        end else if (vWrite) begin
            vRegs[vWbIdx] <= I_VWriteBackData;
        end
    end

    // Scoreboard bits and diagnostic count; frozen while the pipe is not locked
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            sBusy     <= '0;
            vBusy     <= '0;
            busyCount <= '0;
        end else if (I_LOCK) begin
            sBusy     <= sBusyNext;
            vBusy     <= vBusyNext;
            busyCount <= busyCountNext;
        end
    end

    assign O_BusyCount = busyCount;

endmodule
